// File: rtl/arb_pkg.sv
// arb_pkg
//   Shared definitions for the two-master bus arbiter: the FSM state
//   encoding, master identifiers and the saturating tenure-counter helper.
package arb_pkg;

   // Arbiter FSM states; the unused encoding 2'd3 is treated as illegal
   // and steers back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Master identifiers, also the encoding of the 'last' register.
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Increment an 8-bit beat counter, holding at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'd255) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick
//   Combinational two-way round-robin selector.
//   Ports:
//     req[1:0] - request vector (bit 0 = master 0, bit 1 = master 1)
//     last     - master granted most recently
//     pick     - selected master ID (only meaningful when any=1)
//     any      - at least one request is present
module arb_rr_pick
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       pick,
   output logic       any
);

   // On a tie the master that did not go last wins.
   always_comb begin
      any  = |req;
      pick = M0;
      case (req)
         2'b01:   pick = M0;
         2'b10:   pick = M1;
         2'b11:   pick = ~last;
         default: pick = M0;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master round-robin arbiter in front of the SoC bridge. Master 0 is
//   the CPU data port, master 1 the DMA/debug loader. A tenure is cut short
//   after MAX_BURST beats when the other master is waiting. The bus carries
//   zeros (and Bus_wen=0) whenever no granted master is issuing a beat.
//   Ports:
//     clk, rst_n               - clock, asynchronous active-low reset
//     mX_req/addr/wen/wdata    - master X beat request
//     mX_gnt                   - master X owns the bus this cycle
//     mX_ack, mX_rdata         - beat completed, read data (0 unless ack)
//     Bus_addr/wen/wdata       - to the bridge
//     Bus_rdata                - combinational read data from the bridge
module bus_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_wen,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_wen,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_ack,
   output logic          m1_ack,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] Bus_addr,
   output logic          Bus_wen,
   output logic [DW-1:0] Bus_wdata,
   input  logic [DW-1:0] Bus_rdata
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] beats_q, beats_d;

   logic [1:0] pick_req_s;
   logic       pick_s;
   logic       any_s;
   logic       own_req_s;
   logic       limit_s;

   // Candidate requests for the picker: everyone in IDLE, only the
   // non-owner while a tenure is in progress (handover target).
   always_comb begin
      pick_req_s = 2'b00;
      own_req_s  = 1'b0;
      case (state_q)
         IDLE: begin
            pick_req_s = {m1_req, m0_req};
            own_req_s  = 1'b0;
         end
         OWN0: begin
            pick_req_s = {m1_req, 1'b0};
            own_req_s  = m0_req;
         end
         OWN1: begin
            pick_req_s = {1'b0, m0_req};
            own_req_s  = m1_req;
         end
         default: begin
            pick_req_s = 2'b00;
            own_req_s  = 1'b0;
         end
      endcase
   end

   arb_rr_pick u_pick (
      .req  (pick_req_s),
      .last (last_q),
      .pick (pick_s),
      .any  (any_s)
   );

   // Burst limit counts the beat happening in the current cycle; 9 bits so
   // beats_q=255 cannot wrap.
   assign limit_s = (({1'b0, beats_q} + 9'd1) >= 9'(MAX_BURST));

   // Next-state logic: tenure entry clears beats and records the new owner.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beats_d = beats_q;
      case (state_q)
         IDLE: begin
            if (any_s) begin
               state_d = pick_s ? OWN1 : OWN0;
               last_d  = pick_s;
               beats_d = 8'd0;
            end else begin
               state_d = IDLE;
            end
         end
         OWN0, OWN1: begin
            if (own_req_s && !(any_s && limit_s)) begin
               // Owner keeps the bus for another cycle.
               beats_d = sat_inc8(beats_q);
            end else if (any_s) begin
               // Voluntary release or burst limit with the other waiting:
               // hand over directly, no idle bubble.
               state_d = pick_s ? OWN1 : OWN0;
               last_d  = pick_s;
               beats_d = 8'd0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, last-owner and beat-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= M1;
         beats_q <= 8'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   // Bus mux and ack/rdata steering, decoded from the current owner so an
   // asynchronous reset silences the bus immediately.
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      Bus_addr  = '0;
      Bus_wen   = 1'b0;
      Bus_wdata = '0;
      case (state_q)
         OWN0: begin
            m0_gnt = 1'b1;
            if (m0_req) begin
               m0_ack    = 1'b1;
               m0_rdata  = Bus_rdata;
               Bus_addr  = m0_addr;
               Bus_wen   = m0_wen;
               Bus_wdata = m0_wdata;
            end else begin
               m0_ack = 1'b0;
            end
         end
         OWN1: begin
            m1_gnt = 1'b1;
            if (m1_req) begin
               m1_ack    = 1'b1;
               m1_rdata  = Bus_rdata;
               Bus_addr  = m1_addr;
               Bus_wen   = m1_wen;
               Bus_wdata = m1_wdata;
            end else begin
               m1_ack = 1'b0;
            end
         end
         default: begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
         end
      endcase
   end

endmodule
